// File: rtl/sr_flip_flop.sv
// rtl/sr_flip_flop.sv - vectorised clocked SR storage with invalid-input policy and status flags
// Optional macro SR_FLIP_FLOP_ERR_CNT_EN adds an 8-bit saturating count of illegal edges.
module sr_flip_flop #(
   parameter int               WIDTH        = 1,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0,
   parameter int               INVALID_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] invalid,
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
   output logic [7:0]       err_cnt,
`endif
   output logic             err_sticky
);

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] overlap;

   assign overlap = s & r;
   assign qn      = ~q;

   // Out-of-range policy codes fall through to hold.
   always_comb begin
      q_next = q;
      for (int i = 0; i < WIDTH; i++) begin
         case ({s[i], r[i]})
            2'b10: q_next[i] = 1'b1;
            2'b01: q_next[i] = 1'b0;
            2'b11: begin
               case (INVALID_MODE)
                  1:       q_next[i] = 1'b1;
                  2:       q_next[i] = 1'b0;
                  3:       q_next[i] = ~q[i];
                  default: q_next[i] = q[i];
               endcase
            end
            default: q_next[i] = q[i];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q          <= RESET_VAL;
         invalid    <= '0;
         err_sticky <= 1'b0;
      end else begin
         q          <= q_next;
         invalid    <= overlap;
         err_sticky <= err_sticky | (|overlap);
      end
   end

`ifdef SR_FLIP_FLOP_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if ((|overlap) && (err_cnt != 8'hff)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
// tb/tb_sr_flip_flop.sv - directed table-driven bench for sr_flip_flop
// Four 1-bit instances (one per INVALID_MODE) share stimulus; a 4-bit instance covers vector behaviour.
module tb_sr_flip_flop;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s1 = 1'b0;
   logic       r1 = 1'b0;
   logic [3:0] s4 = 4'b0;
   logic [3:0] r4 = 4'b0;

   logic [3:0] q1, qn1, inv1, err1;
   logic [3:0] q4, qn4, inv4;
   logic       err4;
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
   logic [7:0] cnt1 [4];
   logic [7:0] cnt4;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_mode
      sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .INVALID_MODE(m)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .s          (s1),
         .r          (r1),
         .q          (q1[m]),
         .qn         (qn1[m]),
         .invalid    (inv1[m]),
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
         .err_cnt    (cnt1[m]),
`endif
         .err_sticky (err1[m])
      );
   end

   sr_flip_flop #(.WIDTH(4), .RESET_VAL(4'b0000), .INVALID_MODE(0)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .s          (s4),
      .r          (r4),
      .q          (q4),
      .qn         (qn4),
      .invalid    (inv4),
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
      .err_cnt    (cnt4),
`endif
      .err_sticky (err4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic s_i, input logic r_i);
      @(negedge clk);
      s1 = s_i;
      r1 = r_i;
      @(posedge clk);
      #1;
   endtask

   // q holds expected q for modes 0..3 (bit m = mode m)
   typedef struct {
      logic       s;
      logic       r;
      logic [3:0] q;
      logic       inv;
      logic       err;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{s:1'b0, r:1'b0, q:4'b0000, inv:1'b0, err:1'b0};
      tbl[1]  = '{s:1'b1, r:1'b1, q:4'b1010, inv:1'b1, err:1'b1};
      tbl[2]  = '{s:1'b1, r:1'b1, q:4'b0010, inv:1'b1, err:1'b1};
      tbl[3]  = '{s:1'b0, r:1'b0, q:4'b0010, inv:1'b0, err:1'b1};
      tbl[4]  = '{s:1'b1, r:1'b0, q:4'b1111, inv:1'b0, err:1'b1};
      tbl[5]  = '{s:1'b0, r:1'b0, q:4'b1111, inv:1'b0, err:1'b1};
      tbl[6]  = '{s:1'b0, r:1'b0, q:4'b1111, inv:1'b0, err:1'b1};
      tbl[7]  = '{s:1'b0, r:1'b0, q:4'b1111, inv:1'b0, err:1'b1};
      tbl[8]  = '{s:1'b0, r:1'b1, q:4'b0000, inv:1'b0, err:1'b1};
      tbl[9]  = '{s:1'b0, r:1'b0, q:4'b0000, inv:1'b0, err:1'b1};
      tbl[10] = '{s:1'b0, r:1'b0, q:4'b0000, inv:1'b0, err:1'b1};
      tbl[11] = '{s:1'b0, r:1'b0, q:4'b0000, inv:1'b0, err:1'b1};
      tbl[12] = '{s:1'b1, r:1'b1, q:4'b1010, inv:1'b1, err:1'b1};
      tbl[13] = '{s:1'b1, r:1'b1, q:4'b0010, inv:1'b1, err:1'b1};

      // reset held across edges, set requests ignored
      @(posedge clk);
      #1;
      chk("rst_q", {28'd0, q1}, 32'h0);
      chk("rst_qn", {28'd0, qn1}, 32'hf);
      chk("rst_inv", {28'd0, inv1}, 32'h0);
      chk("rst_err", {28'd0, err1}, 32'h0);
      @(negedge clk);
      s1 = 1'b1;
      s4 = 4'hf;
      @(posedge clk);
      #1;
      chk("rst_ignores_edge_q", {28'd0, q1}, 32'h0);
      chk("rst_ignores_edge_q4", {28'd0, q4}, 32'h0);
      @(negedge clk);
      s1 = 1'b0;
      s4 = 4'h0;
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].s, tbl[i].r);
         for (int m = 0; m < 4; m++) begin
            chk($sformatf("v%0d_m%0d_q", i, m), {31'd0, q1[m]}, {31'd0, tbl[i].q[m]});
            chk($sformatf("v%0d_m%0d_qn", i, m), {31'd0, qn1[m]}, {31'd0, ~tbl[i].q[m]});
            chk($sformatf("v%0d_m%0d_inv", i, m), {31'd0, inv1[m]}, {31'd0, tbl[i].inv});
            chk($sformatf("v%0d_m%0d_err", i, m), {31'd0, err1[m]}, {31'd0, tbl[i].err});
         end
      end

      // set everything, then assert reset between edges
      step(1'b1, 1'b0);
      chk("pre_rst_q", {28'd0, q1}, 32'hf);
      chk("pre_rst_err_sticky", {28'd0, err1}, 32'hf);
      @(negedge clk);
      s1 = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_q", {28'd0, q1}, 32'h0);
      chk("async_rst_err", {28'd0, err1}, 32'h0);
      chk("async_rst_inv", {28'd0, inv1}, 32'h0);
`ifdef SR_FLIP_FLOP_ERR_CNT_EN
      chk("async_rst_cnt_m0", {24'd0, cnt1[0]}, 32'd0);
`endif

      // first edge after release performs a normal update
      @(negedge clk);
      rst = 1'b0;
      s1 = 1'b1;
      @(posedge clk);
      #1;
      chk("release_q", {28'd0, q1}, 32'hf);
      chk("release_err", {28'd0, err1}, 32'h0);

      // vector behaviour on the 4-bit hold-mode instance
      chk("w4_err_before", {31'd0, err4}, 32'd0);
      @(negedge clk);
      s1 = 1'b0;
      s4 = 4'b0101;
      r4 = 4'b0011;
      @(posedge clk);
      #1;
      chk("w4_q", {28'd0, q4}, 32'h4);
      chk("w4_qn", {28'd0, qn4}, 32'hb);
      chk("w4_inv", {28'd0, inv4}, 32'h1);
      chk("w4_err", {31'd0, err4}, 32'd1);
      chk("w4_other_err_clean", {28'd0, err1}, 32'h0);
      @(negedge clk);
      s4 = 4'b0000;
      r4 = 4'b0000;
      @(posedge clk);
      #1;
      chk("w4_inv_clears", {28'd0, inv4}, 32'h0);
      chk("w4_q_hold", {28'd0, q4}, 32'h4);

`ifdef SR_FLIP_FLOP_ERR_CNT_EN
      chk("cnt4_one", {24'd0, cnt4}, 32'd1);
      @(negedge clk);
      s4 = 4'hf;
      r4 = 4'hf;
      for (int k = 0; k < 253; k++) @(posedge clk);
      #1;
      chk("cnt4_254", {24'd0, cnt4}, 32'd254);
      @(posedge clk);
      #1;
      chk("cnt4_255", {24'd0, cnt4}, 32'd255);
      for (int k = 0; k < 46; k++) @(posedge clk);
      #1;
      chk("cnt4_saturated", {24'd0, cnt4}, 32'd255);
      chk("cnt1_untouched", {24'd0, cnt1[0]}, 32'd0);
      @(negedge clk);
      s4 = 4'h0;
      r4 = 4'h0;
      rst = 1'b1;
      #1;
      chk("cnt4_rst", {24'd0, cnt4}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sr_flip_flop.md
Name: sr_flip_flop

Overview:
- Clocked set/reset storage element, vectorised to WIDTH independent bits.
- Each bit has its own S/R pair.
- Configurable policy for the illegal S=R=1 condition, plus registered status outputs.
- General-purpose leaf cell for control/status latching in the datapath and in FSM glue logic.

Parameters:
- WIDTH, 1, number of independent SR bits.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q by reset.
- INVALID_MODE, 0, per-bit action on s=r=1: 0=hold, 1=set-dominant, 2=reset-dominant, 3=toggle.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- s  input  WIDTH  per-bit set request.
- r  input  WIDTH  per-bit reset request.
- q  output  WIDTH  stored state.
- qn  output  WIDTH  bitwise complement of q (combinational, ~q).
- invalid  output  WIDTH  registered: bit i = 1 if s[i]&r[i] was sampled at the last rising edge.
- err_sticky  output  1  set on any sampled s&r overlap; cleared only by rst.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; clock port clk, reset port rst.
- Reset:
  - While rst=1: q=RESET_VAL, invalid=0, err_sticky=0, immediately and independent of clk.
  - Clock edges are ignored while rst=1.
- Release: first rising edge with rst=0 performs a normal update.
- Per bit i, at each rising clk with rst=0, latency 1 cycle:
  - s=0,r=0: q hold.
  - s=1,r=0: q=1.
  - s=0,r=1: q=0.
  - s=1,r=1: applied per INVALID_MODE (hold / 1 / 0 / ~q).
- Bits are fully independent; no cross-bit interaction.
- invalid[i] <= s[i]&r[i] every edge; it is not sticky.
- err_sticky <= err_sticky | (|(s&r)).
- Outputs never X after reset; inputs must be synchronous to clk.
- Reset asserted mid-cycle overrides any pending update.
- Reset asserted concurrently with an edge: reset wins.
- INVALID_MODE values outside 0..3 behave as 0 (hold).

Optional Feature:
- Macro: SR_FLIP_FLOP_ERR_CNT_EN.
- When defined:
  - Extra output err_cnt, 8 bits, counting rising edges (rst=0) where |(s&r)=1.
  - Saturates at 255.
  - Cleared to 0 by rst.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: WIDTH=1, rst=1, s=0, r=0 over one edge -> q=0, qn=1, invalid=0, err_sticky=0; rst asserted between edges clears q=1 to 0 without waiting for clk.
- Set then reset: rst=0, s=1,r=0 one edge -> q=1; then s=0,r=1 one edge -> q=0; each change exactly one edge after input.
- Hold: after q=1, s=0,r=0 for 3 edges -> q stays 1; after q=0, same -> q stays 0.
- Invalid, default mode: q=0, s=1,r=1 one edge -> q=0, invalid=1, err_sticky=1; then s=0,r=0 -> invalid=0, err_sticky stays 1 until rst=1.
- Modes: with q=0 and s=r=1, INVALID_MODE=1 -> q=1; INVALID_MODE=2 -> q=0; INVALID_MODE=3 for 2 edges -> q=1 then 0.
- Vector/counter: WIDTH=4, s=4'b0101, r=4'b0011 -> q=4'b0100 from RESET_VAL 0 (hold mode), invalid=4'b0001; with SR_FLIP_FLOP_ERR_CNT_EN, 300 illegal edges -> err_cnt=255.
